// File: rtl/envelope_pkg.sv
// rtl/envelope_pkg.sv - shared constants, state encoding and duty scaler for envelope_pwm
package envelope_pkg;

    localparam int MIDSCALE = 511;
    localparam int ENV_MAX  = 255;
    localparam int PWM_BITS = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    // Centre the sample on midscale, scale by env/256 (floor), re-centre and clamp.
    function automatic logic [PWM_BITS-1:0] scale_duty(input logic [PWM_BITS-1:0] sample,
                                                       input logic [7:0] env);
        logic signed [10:0] s;
        logic signed [19:0] s_w;
        logic signed [19:0] e_w;
        logic signed [19:0] p;
        logic signed [19:0] d;
        s   = $signed({1'b0, sample}) - 11'sd511;
        s_w = 20'(s);
        e_w = $signed(20'(env));
        p   = s_w * e_w;
        d   = (p >>> 8) + 20'sd511;
        if (d < 20'sd0) begin
            scale_duty = '0;
        end else if (d > 20'sd1023) begin
            scale_duty = '1;
        end else begin
            scale_duty = d[PWM_BITS-1:0];
        end
    endfunction

endpackage

// File: rtl/envelope_gen.sv
// rtl/envelope_gen.sv - key synchroniser, tick divider and attack/sustain/release envelope
module envelope_gen
    import envelope_pkg::*;
#(
    parameter int TICK_DIV     = 1200,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_on,
    output logic [7:0] env,
    output logic       busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic          key_m;
    logic          key_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    env_state_t    state;
    env_state_t    state_n;
    logic [7:0]    env_n;
    logic [8:0]    up;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));
    assign up   = {1'b0, env} + 9'(ATTACK_STEP);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m    <= 1'b0;
            key_s    <= 1'b0;
            tick_cnt <= '0;
            state    <= IDLE;
            env      <= '0;
        end else begin
            key_m    <= key_on;
            key_s    <= key_m;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            state    <= state_n;
            env      <= env_n;
        end
    end

    // Key transitions are checked before tick so a gate change always skips that level step.
    always_comb begin
        state_n = state;
        env_n   = env;
        case (state)
            IDLE: begin
                env_n = '0;
                if (key_s) state_n = ATTACK;
            end
            ATTACK: begin
                if (!key_s) begin
                    state_n = RELEASE;
                end else if (env == 8'(ENV_MAX)) begin
                    state_n = SUSTAIN;
                end else if (tick) begin
                    if (up >= 9'(ENV_MAX)) begin
                        env_n   = 8'(ENV_MAX);
                        state_n = SUSTAIN;
                    end else begin
                        env_n = up[7:0];
                    end
                end
            end
            SUSTAIN: begin
                env_n = 8'(ENV_MAX);
                if (!key_s) state_n = RELEASE;
            end
            RELEASE: begin
                if (key_s) begin
                    state_n = ATTACK;
                end else if (env == 8'd0) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (env <= 8'(RELEASE_STEP)) begin
                        env_n   = '0;
                        state_n = IDLE;
                    end else begin
                        env_n = env - 8'(RELEASE_STEP);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                env_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/envelope_pwm.sv
// rtl/envelope_pwm.sv - envelope-scaled 1-bit PWM output stage
module envelope_pwm
    import envelope_pkg::*;
#(
    parameter int TICK_DIV     = 1200,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] sample_in,
    input  logic                key_on,
    output logic                pwm_out,
    output logic [7:0]          env_level,
    output logic                busy,
    output logic                sample_strobe
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_q;

    envelope_gen #(
        .TICK_DIV    (TICK_DIV),
        .ATTACK_STEP (ATTACK_STEP),
        .RELEASE_STEP(RELEASE_STEP)
    ) u_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .key_on(key_on),
        .env   (env_level),
        .busy  (busy)
    );

    // Capture on the last count so the new duty covers a whole period from cnt==0.
    assign sample_strobe = (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            duty_q  <= PWM_BITS'(MIDSCALE);
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            pwm_out <= (cnt < duty_q);
            if (sample_strobe) begin
                duty_q <= scale_duty(sample_in, env_level);
            end
        end
    end

endmodule

// File: tb/tb_envelope_pwm.sv
// tb/tb_envelope_pwm.sv - self-checking bench for envelope_pwm
module tb_envelope_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_on;
    logic [9:0] sample_in;
    logic       pwm_out;
    logic [7:0] env_level;
    logic       busy;
    logic       sample_strobe;

    int checks   = 0;
    int failures = 0;

    logic [7:0] env_q[$];
    logic [7:0] prev_env = 8'd0;

    typedef struct {
        logic [9:0] sample;
        logic       key;
        int         high;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    envelope_pwm #(
        .TICK_DIV    (4),
        .ATTACK_STEP (64),
        .RELEASE_STEP(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .key_on       (key_on),
        .pwm_out      (pwm_out),
        .env_level    (env_level),
        .busy         (busy),
        .sample_strobe(sample_strobe)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Every env_level change must match the next value queued by the stimulus.
    always begin
        @(posedge clk);
        #1;
        if (env_level !== prev_env) begin
            if (env_q.size() == 0) begin
                check("env_unexpected_step", int'(env_level), int'(prev_env));
            end else begin
                check("env_step", int'(env_level), int'(env_q.pop_front()));
            end
            prev_env = env_level;
        end
    end

    task automatic push_attack();
        env_q.push_back(8'd64);
        env_q.push_back(8'd128);
        env_q.push_back(8'd192);
        env_q.push_back(8'd255);
    endtask

    task automatic push_release();
        for (int e = 223; e > 0; e -= 32) env_q.push_back(8'(e));
        env_q.push_back(8'd0);
    endtask

    task automatic wait_env(input logic [7:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (env_level !== target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, int'(env_level), int'(target));
    endtask

    task automatic count_window(input int n, input bit glitch, output int highs, output int strobes);
        logic [9:0] saved;
        saved   = sample_in;
        highs   = 0;
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            highs   += int'(pwm_out);
            strobes += int'(sample_strobe);
            if (glitch && i == 300) sample_in = (saved == 10'h000) ? 10'h3FE : 10'h000;
            if (glitch && i == 900) sample_in = saved;
        end
    endtask

    task automatic measure(output int highs, output int strobes);
        int n;
        n = 0;
        while (!sample_strobe && n < 2100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("strobe_seen", int'(sample_strobe), 1);
        @(posedge clk);
        count_window(1024, 1'b1, highs, strobes);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int h;
        int s;
        int bsum;

        vecs[0] = '{10'h3FE, 1'b1, 1020};
        vecs[1] = '{10'h000, 1'b1, 1};
        vecs[2] = '{10'h1FF, 1'b1, 511};
        vecs[3] = '{10'h2FF, 1'b1, 766};
        vecs[4] = '{10'h0FF, 1'b1, 256};
        vecs[5] = '{10'h3FE, 1'b0, 511};
        vecs[6] = '{10'h000, 1'b0, 511};
        vecs[7] = '{10'h3FE, 1'b1, 1020};

        rst_n     = 1'b0;
        key_on    = 1'b0;
        sample_in = 10'h3FE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_env_level", int'(env_level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sample_strobe", int'(sample_strobe), 0);

        @(negedge clk);
        rst_n = 1'b1;
        count_window(1024, 1'b0, h, s);
        check("idle_period_high", h, 511);
        check("idle_period_strobes", s, 1);
        check("idle_env_level", int'(env_level), 0);
        check("idle_busy", int'(busy), 0);

        for (int k = 0; k < 8; k++) begin
            sample_in = vecs[k].sample;
            if (vecs[k].key != key_on) begin
                if (vecs[k].key) begin
                    push_attack();
                    key_on = 1'b1;
                    wait_env(8'd255, 200, "attack_reach_max");
                end else begin
                    push_release();
                    key_on = 1'b0;
                    wait_env(8'd0, 400, "release_reach_zero");
                end
            end
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("busy[%0d]", k), int'(busy), int'(vecs[k].key));
            check($sformatf("env_level[%0d]", k), int'(env_level), vecs[k].key ? 255 : 0);
            measure(h, s);
            check($sformatf("duty_high[%0d]", k), h, vecs[k].high);
            check($sformatf("strobes[%0d]", k), s, 1);
        end

        repeat (50) @(posedge clk);
        @(negedge clk);
        env_q.push_back(8'd0);
        key_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_pwm_out", int'(pwm_out), 0);
        check("midrst_env_level", int'(env_level), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_window(1024, 1'b0, h, s);
        check("post_rst_period_high", h, 511);
        check("post_rst_strobes", s, 1);

        env_q.push_back(8'd64);
        env_q.push_back(8'd128);
        key_on = 1'b1;
        wait_env(8'd128, 100, "retrig_attack_128");
        key_on = 1'b0;
        env_q.push_back(8'd96);
        env_q.push_back(8'd64);
        wait_env(8'd64, 100, "retrig_release_64");
        check("retrig_busy_release", int'(busy), 1);
        key_on = 1'b1;
        env_q.push_back(8'd128);
        env_q.push_back(8'd192);
        env_q.push_back(8'd255);
        wait_env(8'd255, 100, "retrig_reattack_255");
        check("retrig_busy_sustain", int'(busy), 1);
        push_release();
        key_on = 1'b0;
        wait_env(8'd0, 400, "retrig_release_zero");
        @(posedge clk);
        #1;
        check("retrig_idle_busy", int'(busy), 0);

        @(posedge clk);
        #2 key_on = 1'b1;
        #2 key_on = 1'b0;
        bsum = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            bsum += int'(busy);
        end
        check("glitch_busy_cycles", bsum, 0);
        check("glitch_env_level", int'(env_level), 0);

        repeat (4) @(posedge clk);
        #1;
        check("env_queue_drained", env_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
